// File: rtl/rf_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_if
//
// Bundles the write-back arbiter bus signals.
//   ALU side   : alu_valid, alu_rd[4:0], alu_data[31:0] in; alu_stall out
//   Load return: ld_valid, ld_rd[4:0], ld_data[31:0] in; ld_ready out
//   RF write   : we3, a3[4:0], wd3[31:0] out
//   Issue      : issue_valid, issue_rd[4:0] in
//   Scoreboard : busy[31:0] out (only with WB_SCOREBOARD_EN defined)
//
// Modport slave is taken by the arbiter; modport master is the environment.
// ---------------------------------------------------------------------------
interface rf_wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;

    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;

    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;

    logic        issue_valid;
    logic [4:0]  issue_rd;
`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy;
`endif

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_stall,
        input  ld_valid, ld_rd, ld_data,
        output ld_ready,
        output we3, a3, wd3,
        input  issue_valid, issue_rd
`ifdef WB_SCOREBOARD_EN
        , output busy
`endif
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_stall,
        output ld_valid, ld_rd, ld_data,
        input  ld_ready,
        input  we3, a3, wd3,
        output issue_valid, issue_rd
`ifdef WB_SCOREBOARD_EN
        , input busy
`endif
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Merges ALU results and load returns onto the single register-file write
// port. Loads are buffered in a DEPTH-entry FIFO; the ALU normally wins, but
// after STARVE_MAX consecutive wins over a non-empty FIFO a registered
// one-cycle alu_stall hands the port to the FIFO head. The write port is
// registered; writes to x0 are consumed without asserting we3.
//
// Parameters: DEPTH (power of two, 2..16), STARVE_MAX (1..15)
// Ports     : clk, rst_n (async, active low), wb (rf_wb_arbiter_if.slave)
// Option    : define WB_SCOREBOARD_EN to add the busy pending-load flags,
//             set by issue_valid/issue_rd, cleared by FIFO-sourced writes.
// ---------------------------------------------------------------------------
module rf_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.slave  wb
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT   = (PW+1)'(DEPTH);
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    // FIFO storage: {rd, data}
    logic [36:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          empty, full;
    logic [4:0]    head_rd;
    logic [31:0]   head_data;
    logic          push, pop;

    // Arbitration
    logic          sel_alu, sel_fifo;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    // Starvation control
    logic [3:0]    starve_q, starve_d;
    logic          stall_q, stall_d;

    // Registered write port
    logic          we3_q;
    logic [4:0]    a3_q;
    logic [31:0]   wd3_q;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign {head_rd, head_data} = mem[rd_ptr_q];

    // ld_ready comes from registered occupancy only, so a full FIFO being
    // popped this cycle still refuses the new load.
    assign push = wb.ld_valid && !full;
    assign pop  = sel_fifo;

    always_comb begin
        sel_alu  = 1'b0;
        sel_fifo = 1'b0;
        if (stall_q) begin
            sel_fifo = !empty;
        end else if (wb.alu_valid) begin
            sel_alu = 1'b1;
        end else begin
            sel_fifo = !empty;
        end
        sel_rd   = sel_alu ? wb.alu_rd   : head_rd;
        sel_data = sel_alu ? wb.alu_data : head_data;
    end

    // The counter holds STARVE_MAX during the stall cycle and clears there,
    // because the ALU cannot be selected while alu_stall is high.
    always_comb begin
        starve_d = '0;
        stall_d  = 1'b0;
        if (sel_alu && !empty) begin
            starve_d = starve_q + 4'd1;
            stall_d  = (starve_d == STARVE_LIM);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {wb.ld_rd, wb.ld_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we3_q    <= 1'b0;
            a3_q     <= '0;
            wd3_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we3_q    <= (sel_alu || sel_fifo) && (sel_rd != 5'd0);
            if (sel_alu || sel_fifo) begin
                a3_q  <= sel_rd;
                wd3_q <= sel_data;
            end
        end
    end

    assign wb.ld_ready  = !full;
    assign wb.alu_stall = stall_q;
    assign wb.we3       = we3_q;
    assign wb.a3        = a3_q;
    assign wb.wd3       = wd3_q;

`ifdef WB_SCOREBOARD_EN
    logic [31:0] busy_q, busy_set, busy_clr;

    // Clear lands on the same edge that raises we3 for the FIFO write;
    // a coincident set takes precedence, and bit 0 is never held.
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (wb.issue_valid) begin
            busy_set[wb.issue_rd] = 1'b1;
        end
        if (sel_fifo && (head_rd != 5'd0)) begin
            busy_clr[head_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~busy_clr) | busy_set) & ~32'd1;
        end
    end

    assign wb.busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = wb.issue_valid ^ (^wb.issue_rd);
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Directed bench for rf_wb_arbiter (DEPTH=4, STARVE_MAX=3). Inputs change
// 1 time unit after the rising edge; outputs are checked at the same point,
// i.e. they show what the preceding edge registered.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    rf_wb_arbiter_if wb();

    rf_wb_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb.alu_valid   = 1'b0;
        wb.alu_rd      = '0;
        wb.alu_data    = '0;
        wb.ld_valid    = 1'b0;
        wb.ld_rd       = '0;
        wb.ld_data     = '0;
        wb.issue_valid = 1'b0;
        wb.issue_rd    = '0;
    endtask

    // Fill-test expectations: ALU results 11..23, loads 1..4
    int exp_a3 [17] = '{11, 12, 13, 14, 1, 15, 16, 17, 2, 18, 19, 20, 3, 21, 22, 23, 4};
    bit exp_st [17] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  next_rd;
        bit  stalled;
        logic [31:0] exp_wd;

        idle_inputs();
        rst_n = 1'b0;

        // Reset state
        #12;
        check("rst_we3", wb.we3, 0);
        check("rst_stall", wb.alu_stall, 0);
        check("rst_ld_ready", wb.ld_ready, 1);
        check("rst_a3", wb.a3, 0);
        check("rst_wd3", wb.wd3, 0);
        #10 rst_n = 1'b1;
        step();
        check("post_rst_we3", wb.we3, 0);

        // ALU-only write, one cycle latency
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_data = 32'hDEADBEEF;
        step();
        wb.alu_valid = 1'b0;
        check("alu_we3", wb.we3, 1);
        check("alu_a3", wb.a3, 5);
        check("alu_wd3", wb.wd3, 32'hDEADBEEF);
        step();
        check("alu_we3_off", wb.we3, 0);

        // ALU write to x0 is dropped
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd0; wb.alu_data = 32'h1234;
        step();
        wb.alu_valid = 1'b0;
        check("x0_alu_we3", wb.we3, 0);
        check("x0_alu_ld_ready", wb.ld_ready, 1);

        // Load into empty FIFO: no write on the edge that accepts it
        wb.ld_valid = 1'b1; wb.ld_rd = 5'd8; wb.ld_data = 32'h8888;
        step();
        wb.ld_valid = 1'b0;
        check("lat_we3_early", wb.we3, 0);
        step();
        check("lat_we3", wb.we3, 1);
        check("lat_a3", wb.a3, 8);
        check("lat_wd3", wb.wd3, 32'h8888);
        step();
        check("lat_we3_off", wb.we3, 0);

        // Load to x0 is popped silently
        wb.ld_valid = 1'b1; wb.ld_rd = 5'd0; wb.ld_data = 32'h55;
        step();
        wb.ld_valid = 1'b0;
        step();
        check("x0_ld_we3", wb.we3, 0);
        step();
        check("x0_ld_we3_after", wb.we3, 0);
        check("x0_ld_ready", wb.ld_ready, 1);

        // Contention: ALU first, load in first ALU-idle cycle
        wb.ld_valid = 1'b1; wb.ld_rd = 5'd9; wb.ld_data = 32'h9999;
        step();
        wb.ld_valid = 1'b0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd6; wb.alu_data = 32'h6666;
        step();
        wb.alu_valid = 1'b0;
        check("cont_a3_alu", wb.a3, 6);
        check("cont_wd3_alu", wb.wd3, 32'h6666);
        step();
        check("cont_we3_ld", wb.we3, 1);
        check("cont_a3_ld", wb.a3, 9);
        check("cont_wd3_ld", wb.wd3, 32'h9999);
        step();

        // FIFO fill with ALU valid every cycle; upstream holds while stalled
        next_rd = 11;
        for (int i = 0; i < 17; i++) begin
            wb.alu_valid = 1'b1;
            wb.alu_rd    = 5'(next_rd);
            wb.alu_data  = 32'hA000 + 32'(next_rd);
            if (i < 4) begin
                wb.ld_valid = 1'b1;
                wb.ld_rd    = 5'(i + 1);
                wb.ld_data  = 32'h100 + 32'(i + 1);
            end else begin
                wb.ld_valid = 1'b0;
            end
            stalled = wb.alu_stall;
            step();
            if (!stalled) next_rd++;
            exp_wd = (exp_a3[i] < 11) ? 32'h100 + 32'(exp_a3[i]) : 32'hA000 + 32'(exp_a3[i]);
            check($sformatf("fill_we3_%0d", i), wb.we3, 1);
            check($sformatf("fill_a3_%0d", i), wb.a3, 32'(exp_a3[i]));
            check($sformatf("fill_wd3_%0d", i), wb.wd3, exp_wd);
            check($sformatf("fill_stall_%0d", i), wb.alu_stall, 32'(exp_st[i]));
            if (i == 3) check("fill_ld_ready_full", wb.ld_ready, 0);
            if (i == 4) check("fill_ld_ready_pop", wb.ld_ready, 1);
        end
        idle_inputs();
        step();
        check("fill_drained_we3", wb.we3, 0);

`ifdef WB_SCOREBOARD_EN
        // Scoreboard set/clear and set-wins
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd7;
        step();
        wb.issue_valid = 1'b0;
        check("sb_set", wb.busy[7], 1);
        wb.ld_valid = 1'b1; wb.ld_rd = 5'd7; wb.ld_data = 32'h77;
        step();
        wb.ld_valid = 1'b0;
        check("sb_pending_we3", wb.we3, 0);
        check("sb_pending", wb.busy[7], 1);
        step();
        check("sb_clr_we3", wb.we3, 1);
        check("sb_clr_a3", wb.a3, 7);
        check("sb_clr", wb.busy[7], 0);
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd7;
        step();
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd0;
        wb.ld_valid = 1'b1; wb.ld_rd = 5'd7; wb.ld_data = 32'h78;
        step();
        wb.ld_valid = 1'b0;
        check("sb_x0", wb.busy[0], 0);
        check("sb_reset7", wb.busy[7], 1);
        wb.issue_valid = 1'b1; wb.issue_rd = 5'd7;
        step();
        wb.issue_valid = 1'b0;
        check("sb_win_we3", wb.we3, 1);
        check("sb_win_a3", wb.a3, 7);
        check("sb_win", wb.busy[7], 1);
        step();
`endif

        // Reset mid-burst with 3 loads queued
        for (int i = 0; i < 3; i++) begin
            wb.alu_valid = 1'b1; wb.alu_rd = 5'(11 + i); wb.alu_data = 32'hB000 + 32'(i);
            wb.ld_valid  = 1'b1; wb.ld_rd  = 5'(i + 1);  wb.ld_data  = 32'hC000 + 32'(i);
            step();
        end
        idle_inputs();
        check("burst_we3", wb.we3, 1);
        check("burst_a3", wb.a3, 13);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_we3", wb.we3, 0);
        check("mid_rst_ld_ready", wb.ld_ready, 1);
        check("mid_rst_stall", wb.alu_stall, 0);
`ifdef WB_SCOREBOARD_EN
        check("mid_rst_busy", wb.busy, 0);
`endif
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stale_we3_%0d", i), wb.we3, 0);
            check($sformatf("stale_ld_ready_%0d", i), wb.ld_ready, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4: load-return FIFO entries, power of two, 2 to 16.
REQ-002 The module SHALL have parameter STARVE_MAX, default 3: consecutive cycles a non-empty FIFO may lose to the ALU, 1 to 15.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port alu_valid, input, 1 bit: ALU result present this cycle; it has no ready.
REQ-006 The module SHALL have port alu_rd, input, 5 bits: ALU destination register.
REQ-007 The module SHALL have port alu_data, input, 32 bits: ALU result.
REQ-008 The module SHALL have port alu_stall, output, 1 bit: when high, upstream holds its ALU result and alu_valid is ignored this cycle.
REQ-009 The module SHALL have ports ld_valid, input, 1 bit, and ld_ready, output, 1 bit: load-return valid/ready handshake.
REQ-010 The module SHALL have ports ld_rd, input, 5 bits, and ld_data, input, 32 bits: load destination register and load data.
REQ-011 The module SHALL have ports we3, output, 1 bit; a3, output, 5 bits; wd3, output, 32 bits: register-file write port.
REQ-012 The module SHALL have ports issue_valid, input, 1 bit, and issue_rd, input, 5 bits: a load was issued to destination issue_rd.
REQ-013 The module SHALL have port busy, output, 32 bits: per-register pending-load flags, present only under WB_SCOREBOARD_EN.

Function
REQ-014 A load SHALL be accepted into the FIFO in a cycle where ld_valid and ld_ready are both high; ld_ready SHALL equal FIFO not full.
REQ-015 A FIFO that is full and popped in the same cycle SHALL keep ld_ready low that cycle; no bypass.
REQ-016 The write port SHALL be registered: a source selected in cycle N drives we3/a3/wd3 in cycle N+1, and we3 SHALL be low in cycles where nothing is selected.
REQ-017 Selection SHALL follow this priority: alu_stall high selects the FIFO head; otherwise alu_valid selects the ALU; otherwise a non-empty FIFO selects its head.
REQ-018 A selection with destination register 0 SHALL be consumed (ALU result taken, FIFO entry popped) with we3 held low.
REQ-019 The starvation counter SHALL increment in each cycle where the ALU is selected while the FIFO is non-empty, and SHALL clear otherwise.
REQ-020 alu_stall SHALL be registered and SHALL go high for exactly one cycle after the starvation counter reaches STARVE_MAX, after which the counter SHALL clear.
REQ-021 A load entering an empty FIFO SHALL be written no earlier than the cycle after acceptance, i.e. at least 2 cycles from the ld handshake to we3.
REQ-022 FIFO read and write pointers SHALL wrap modulo DEPTH, and order SHALL be strictly FIFO.
REQ-023 With WB_SCOREBOARD_EN, issue_valid with issue_rd not 0 SHALL set busy[issue_rd] on the next edge.
REQ-024 With WB_SCOREBOARD_EN, a FIFO-sourced write SHALL clear busy[a3] in the same cycle that write drives we3.
REQ-025 If a set and a clear target the same register in the same cycle, the set SHALL win; busy[0] SHALL always read 0.

Reset
REQ-026 rst_n low SHALL asynchronously force we3, alu_stall and the starvation counter to 0, empty the FIFO (ld_ready=1), and clear busy.
REQ-027 After reset, a3 and wd3 SHALL read 0.
REQ-028 Reset mid-operation SHALL discard all FIFO contents and all in-flight writes, and no write SHALL occur in the first cycle after release.
REQ-029 Reset deassertion SHALL be sampled on a clk edge; logic is active from the first edge after rst_n rises.

Configuration
REQ-030 With macro WB_SCOREBOARD_EN defined, the busy port and its set/clear logic SHALL be present; without it, the busy port SHALL be absent, issue_valid and issue_rd SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification
REQ-031 ALU-only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF in cycle N -> we3=1, a3=5, wd3=0xDEADBEEF in cycle N+1.
REQ-032 x0 drop: alu_rd=0, alu_data=0x1234 -> we3 stays 0 and ld_ready is unaffected.
REQ-033 FIFO fill (DEPTH=4, ALU valid every cycle): 4 loads accepted, then ld_ready=0; with STARVE_MAX=3, alu_stall pulses once per 4 cycles and the loads retire in order rd 1,2,3,4.
REQ-034 Contention: alu_valid and a non-empty FIFO together -> ALU written first, load written in the first ALU-idle cycle.
REQ-035 Scoreboard: issue rd=7, load return rd=7 -> busy[7] is 1 until the cycle we3 writes 7, then 0; a same-cycle issue 7 and write 7 leaves busy[7]=1.
REQ-036 Reset mid-burst: FIFO holding 3 entries, rst_n pulsed low between edges -> we3=0 and busy=0 immediately, ld_ready=1, and no stale write occurs after release.
